// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the writeback slice: datapath width, register
// index type and the load funct3 encodings.
package rv32_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } funct3_ld_e;

    function automatic logic [XLEN-1:0] sext8(input logic [7:0] b);
        return {{(XLEN-8){b[7]}}, b};
    endfunction

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] h);
        return {{(XLEN-16){h[15]}}, h};
    endfunction

endpackage

// File: rtl/wb_regfile_load_extend.sv
// Load aligner/extender: picks byte/halfword at the offset and extends per funct3.
// Purely combinational, no flow control.
module load_extend
    import rv32_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_off,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    // Halfword offset drops off[0]: misaligned halfword loads truncate, never trap.
    assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            F3_LB:   o_data = sext8(w_byte);
            F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_LH:   o_data = sext16(w_half);
            F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result select, load extension, 32x32 register file with write-through reads.
// Reads are zero-latency (same-cycle bypass); writes commit on the clock edge; no backpressure.
module wb_regfile
    import rv32_pkg::*;
#(
    parameter int XLEN_P  = XLEN,
    parameter int NREGS_P = NREGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteW,
    input  logic              ResultSrcW,
    input  logic [2:0]        Funct3W,
    input  logic [XLEN_P-1:0] ResultW,
    input  logic [XLEN_P-1:0] ReadDataW,
    input  logic [4:0]        RdW,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    output logic [XLEN_P-1:0] RD1D,
    output logic [XLEN_P-1:0] RD2D,
    output logic [XLEN_P-1:0] WriteDataW,
    output logic              WbValidW
);

    logic              r_settling;
    logic [XLEN_P-1:0] r_regs [NREGS_P];
    logic [XLEN_P-1:0] w_load_data;
    logic              w_wb_vld;

    load_extend u_load_extend (
        .i_funct3 (Funct3W),
        .i_off    (ResultW[1:0]),
        .i_rdata  (ReadDataW),
        .o_data   (w_load_data)
    );

    assign WriteDataW = ResultSrcW ? w_load_data : ResultW;

    // One dead cycle after reset release so a stale pipeline write cannot land.
    always_ff @(posedge clk) begin
        if (!reset) r_settling <= 1'b1;
        else        r_settling <= 1'b0;
    end

    assign w_wb_vld = reset & ~r_settling & RegWriteW & (RdW != 5'd0);
    assign WbValidW = w_wb_vld;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS_P; i++) r_regs[i] <= '0;
        end else if (w_wb_vld) begin
            r_regs[RdW] <= WriteDataW;
        end
    end

    always_comb begin
        RD1D = r_regs[Rs1D];
        if (Rs1D == 5'd0)                  RD1D = '0;
        else if (w_wb_vld && RdW == Rs1D)  RD1D = WriteDataW;
    end

    always_comb begin
        RD2D = r_regs[Rs2D];
        if (Rs2D == 5'd0)                  RD2D = '0;
        else if (w_wb_vld && RdW == Rs2D)  RD2D = WriteDataW;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset/settle, load extension, bypass, x0, mid-run reset.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteW;
    logic        ResultSrcW;
    logic [2:0]  Funct3W;
    logic [31:0] ResultW;
    logic [31:0] ReadDataW;
    logic [4:0]  RdW;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] WriteDataW;
    logic        WbValidW;

    int n_cmp = 0;
    int n_err = 0;

    wb_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .Funct3W    (Funct3W),
        .ResultW    (ResultW),
        .ReadDataW  (ReadDataW),
        .RdW        (RdW),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RD1D       (RD1D),
        .RD2D       (RD2D),
        .WriteDataW (WriteDataW),
        .WbValidW   (WbValidW)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic load_vec(input string tag, input logic [2:0] f3, input logic [1:0] off,
                            input logic [31:0] exp);
        tick();
        Funct3W = f3;
        ResultW = {30'd0, off};
        sample();
        check_val(tag, WriteDataW, exp);
    endtask

    initial begin
        reset      = 1'b0;
        RegWriteW  = 1'b1;
        ResultSrcW = 1'b0;
        Funct3W    = 3'b010;
        ResultW    = 32'h0;
        ReadDataW  = 32'h0;
        RdW        = 5'd5;
        Rs1D       = 5'd5;
        Rs2D       = 5'd5;

        // Reset held two cycles with a write request pending
        tick();
        tick();
        sample();
        check_val("rst_vld", {31'd0, WbValidW}, 32'd0);
        check_val("rst_rd1", RD1D, 32'd0);
        check_val("rst_rd2", RD2D, 32'd0);
        check_val("rst_wdata", WriteDataW, 32'd0);

        // Settle cycle: write must be suppressed
        tick();
        reset   = 1'b1;
        ResultW = 32'h0000_1234;
        sample();
        check_val("settle_vld", {31'd0, WbValidW}, 32'd0);
        check_val("settle_rd1", RD1D, 32'd0);

        // Same request one cycle later commits
        tick();
        sample();
        check_val("wr5_vld", {31'd0, WbValidW}, 32'd1);
        check_val("wr5_bypass", RD1D, 32'h0000_1234);
        tick();
        RegWriteW = 1'b0;
        sample();
        check_val("wr5_stored", RD1D, 32'h0000_1234);

        // Load extension
        ResultSrcW = 1'b1;
        ReadDataW  = 32'h80FF_7F01;
        load_vec("lb_off3",  3'b000, 2'd3, 32'hFFFF_FF80);
        load_vec("lbu_off3", 3'b100, 2'd3, 32'h0000_0080);
        load_vec("lh_off2",  3'b001, 2'd2, 32'hFFFF_80FF);
        load_vec("lhu_off0", 3'b101, 2'd0, 32'h0000_7F01);
        load_vec("lw",       3'b010, 2'd0, 32'h80FF_7F01);
        load_vec("lh_off1",  3'b001, 2'd1, 32'h0000_7F01);
        load_vec("lb_off1",  3'b000, 2'd1, 32'h0000_007F);
        load_vec("lbu_off2", 3'b100, 2'd2, 32'h0000_00FF);
        load_vec("rsv_011",  3'b011, 2'd2, 32'h80FF_7F01);
        load_vec("lhu_off3", 3'b101, 2'd3, 32'h0000_80FF);

        // Load result written to x10
        tick();
        Funct3W   = 3'b000;
        ResultW   = 32'h0000_0003;
        RegWriteW = 1'b1;
        RdW       = 5'd10;
        tick();
        RegWriteW = 1'b0;
        Rs1D      = 5'd10;
        sample();
        check_val("x10_load", RD1D, 32'hFFFF_FF80);

        // Bypass on both ports
        ResultSrcW = 1'b0;
        tick();
        RegWriteW = 1'b1;
        RdW       = 5'd7;
        ResultW   = 32'hDEAD_BEEF;
        Rs1D      = 5'd7;
        Rs2D      = 5'd7;
        sample();
        check_val("byp_rd1", RD1D, 32'hDEAD_BEEF);
        check_val("byp_rd2", RD2D, 32'hDEAD_BEEF);
        tick();
        RegWriteW = 1'b0;
        ResultW   = 32'h0;
        sample();
        check_val("x7_rd1", RD1D, 32'hDEAD_BEEF);
        check_val("x7_rd2", RD2D, 32'hDEAD_BEEF);

        // x0 protection
        tick();
        RegWriteW = 1'b1;
        RdW       = 5'd0;
        ResultW   = 32'hFFFF_FFFF;
        Rs1D      = 5'd0;
        Rs2D      = 5'd0;
        sample();
        check_val("x0_vld", {31'd0, WbValidW}, 32'd0);
        check_val("x0_rd1", RD1D, 32'd0);
        check_val("x0_rd2", RD2D, 32'd0);
        tick();
        RegWriteW = 1'b0;
        sample();
        check_val("x0_rd1_next", RD1D, 32'd0);

        // RegWriteW=0: no commit, value still visible on WriteDataW
        tick();
        RegWriteW = 1'b1;
        RdW       = 5'd9;
        ResultW   = 32'h0000_0099;
        tick();
        RegWriteW = 1'b0;
        ResultW   = 32'h0000_0055;
        Rs1D      = 5'd9;
        sample();
        check_val("nowr_vld", {31'd0, WbValidW}, 32'd0);
        check_val("nowr_wdata", WriteDataW, 32'h0000_0055);
        check_val("nowr_rd1", RD1D, 32'h0000_0099);
        tick();
        sample();
        check_val("nowr_x9", RD1D, 32'h0000_0099);

        // Fill x1..x31 with distinct values and read them back
        for (int i = 1; i < 32; i++) begin
            tick();
            RegWriteW = 1'b1;
            RdW       = 5'(i);
            ResultW   = 32'hA500_0000 | (i * 32'h0001_0101);
        end
        tick();
        RegWriteW = 1'b0;
        for (int i = 1; i < 32; i++) begin
            Rs1D = 5'(i);
            Rs2D = 5'(32 - i);
            #1;
            check_val($sformatf("fill_rd1_x%0d", i), RD1D, 32'hA500_0000 | (i * 32'h0001_0101));
            check_val($sformatf("fill_rd2_x%0d", 32 - i), RD2D,
                      32'hA500_0000 | ((32 - i) * 32'h0001_0101));
        end

        // Mid-run reset with a concurrent write to x3
        tick();
        reset     = 1'b0;
        RegWriteW = 1'b1;
        RdW       = 5'd3;
        ResultW   = 32'h0000_ABCD;
        Rs1D      = 5'd3;
        sample();
        check_val("mrst_vld", {31'd0, WbValidW}, 32'd0);
        tick();
        reset = 1'b1;
        sample();
        check_val("mrst_settle_vld", {31'd0, WbValidW}, 32'd0);
        check_val("mrst_settle_rd1", RD1D, 32'd0);
        tick();
        RegWriteW = 1'b0;
        for (int i = 1; i < 32; i++) begin
            Rs1D = 5'(i);
            Rs2D = 5'(i);
            #1;
            check_val($sformatf("mrst_rd1_x%0d", i), RD1D, 32'd0);
            check_val($sformatf("mrst_rd2_x%0d", i), RD2D, 32'd0);
        end

        // Normal write resumes after the settle cycle
        tick();
        RegWriteW = 1'b1;
        RdW       = 5'd3;
        ResultW   = 32'h0000_3333;
        Rs1D      = 5'd3;
        tick();
        RegWriteW = 1'b0;
        sample();
        check_val("post_rst_x3", RD1D, 32'h0000_3333);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
